parking_meter_ctrl: RTL and testbench

Sequencing controller for the Lab 4 parking meter. Holds the remaining time as a 4-digit BCD seconds count, applies coin/preset requests, counts down once per second, and generates the 0.5 Hz square wave. Its `bcd_time` and `clk_half_hz` outputs drive the display flasher and the 7-segment driver directly.

---
 rtl/parking_meter_pkg.sv | 36 +++
 rtl/parking_meter_if.sv | 26 ++
 rtl/bcd4_addsub.sv | 38 +++
 rtl/parking_meter_ctrl.sv | 109 ++++++++++
 tb/tb_parking_meter_ctrl.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/parking_meter_pkg.sv
// Shared types and BCD constants for the parking meter sequencing controller.
package parking_meter_pkg;

    typedef enum logic [1:0] {
        EXPIRED = 2'd0,
        RUNNING = 2'd1,
        LOW     = 2'd2
    } meter_state_e;

    typedef enum logic {
        BCD_ADD = 1'b0,
        BCD_SUB = 1'b1
    } bcd_op_e;

    localparam logic [15:0] BCD_ZERO       = 16'h0000;
    localparam logic [15:0] BCD_ONE        = 16'h0001;
    localparam logic [15:0] BCD_AMT_50     = 16'h0050;
    localparam logic [15:0] BCD_AMT_150    = 16'h0150;
    localparam logic [15:0] BCD_AMT_200    = 16'h0200;
    localparam logic [15:0] BCD_AMT_500    = 16'h0500;
    localparam logic [15:0] BCD_PRESET_10  = 16'h0010;
    localparam logic [15:0] BCD_PRESET_205 = 16'h0205;
    localparam logic [15:0] BCD_LOW_THRESH = 16'h0180;
    localparam logic [15:0] BCD_MAX        = 16'h9999;

    // Valid BCD orders the same as binary, so a plain magnitude compare is enough.
    function automatic meter_state_e decode_state(input logic [15:0] bcd);
        if (bcd == BCD_ZERO)
            return EXPIRED;
        else if (bcd <= BCD_LOW_THRESH)
            return LOW;
        else
            return RUNNING;
    endfunction

endpackage

// File: rtl/parking_meter_if.sv
// Request pulses in, remaining time / flasher / state out.
interface parking_meter_if;
    import parking_meter_pkg::*;

    logic         add_50;
    logic         add_150;
    logic         add_200;
    logic         add_500;
    logic         preset_10;
    logic         preset_205;
    logic [15:0]  bcd_time;
    logic         clk_half_hz;
    logic         tick_1hz;
    meter_state_e state;

    modport master (
        output add_50, add_150, add_200, add_500, preset_10, preset_205,
        input  bcd_time, clk_half_hz, tick_1hz, state
    );

    modport slave (
        input  add_50, add_150, add_200, add_500, preset_10, preset_205,
        output bcd_time, clk_half_hz, tick_1hz, state
    );

endinterface

// File: rtl/bcd4_addsub.sv
// Combinational 4-digit BCD add/subtract; adds saturate at 9999, subtracts floor at 0000.
module bcd4_addsub
    import parking_meter_pkg::*;
(
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  bcd_op_e     op_i,
    output logic [15:0] y_o
);

    logic [4:0]  digit;
    logic        carry;
    logic [15:0] raw;

    always_comb begin
        // NOTE: blocking assignments here, so the carry ripples digit to digit within one evaluation.
        digit = '0;
        carry = 1'b0;
        raw   = '0;
        for (int i = 0; i < 4; i++) begin
            if (op_i == BCD_ADD) begin
                digit = {1'b0, a_i[4*i +: 4]} + {1'b0, b_i[4*i +: 4]} + {4'b0, carry};
                carry = (digit > 5'd9);
                if (carry) digit = digit - 5'd10;
            end else begin
                digit = {1'b0, a_i[4*i +: 4]} - {1'b0, b_i[4*i +: 4]} - {4'b0, carry};
                carry = digit[4];
                if (carry) digit = digit + 5'd10;
            end
            raw[4*i +: 4] = digit[3:0];
        end
        if (carry)
            y_o = (op_i == BCD_ADD) ? BCD_MAX : BCD_ZERO;
        else
            y_o = raw;
    end

endmodule

// File: rtl/parking_meter_ctrl.sv
// Parking meter sequencer: 1 s prescaler, request priority, BCD countdown,
// 0.5 Hz flasher clock and EXPIRED/LOW/RUNNING decode.
module parking_meter_ctrl
    import parking_meter_pkg::*;
#(
    parameter int unsigned CLK_HZ = 100_000_000
) (
    input  logic            clk,
    input  logic            rst_n,
    parking_meter_if.slave  bus
);

    localparam int          PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRESC_TC = PW'(CLK_HZ - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic          tick_q, tick_d;
    logic          half_q, half_d;
    logic [15:0]   count_q, count_d;
    meter_state_e  state_q, state_d;

    logic          req_valid;
    logic          req_preset;
    logic [15:0]   req_value;
    logic [15:0]   dec_val;
    logic [15:0]   add_base;
    logic [15:0]   add_val;
    logic          restart;

    bcd4_addsub u_dec (
        .a_i  (count_q),
        .b_i  (BCD_ONE),
        .op_i (BCD_SUB),
        .y_o  (dec_val)
    );

    // A coin landing on a tick is added to the already-decremented count.
    assign add_base = tick_q ? dec_val : count_q;

    bcd4_addsub u_add (
        .a_i  (add_base),
        .b_i  (req_value),
        .op_i (BCD_ADD),
        .y_o  (add_val)
    );

    always_comb begin
        // NOTE: every output gets a default first, so no path can infer a latch.
        req_valid  = 1'b1;
        req_preset = 1'b0;
        req_value  = BCD_ZERO;
        if (bus.preset_205) begin
            req_preset = 1'b1;
            req_value  = BCD_PRESET_205;
        end else if (bus.preset_10) begin
            req_preset = 1'b1;
            req_value  = BCD_PRESET_10;
        end else if (bus.add_500) begin
            req_value  = BCD_AMT_500;
        end else if (bus.add_200) begin
            req_value  = BCD_AMT_200;
        end else if (bus.add_150) begin
            req_value  = BCD_AMT_150;
        end else if (bus.add_50) begin
            req_value  = BCD_AMT_50;
        end else begin
            req_valid  = 1'b0;
        end
    end

    always_comb begin
        count_d = count_q;
        if (req_valid)
            count_d = req_preset ? req_value : add_val;
        else if (tick_q)
            count_d = dec_val;

        // Presets and wake-ups from 0000 realign the second boundary to the request.
        restart = req_valid && (req_preset || (count_q == BCD_ZERO && count_d != BCD_ZERO));

        presc_d = (restart || presc_q == PRESC_TC) ? '0 : presc_q + PW'(1);
        tick_d  = !restart && (presc_q == PRESC_TC);
        half_d  = restart ? 1'b0 : (half_q ^ tick_q);
        state_d = decode_state(count_d);
    end

    always_ff @(posedge clk) begin
        // NOTE: synchronous reset: rst_n is only sampled at the clock edge and wins over any request or tick.
        if (!rst_n) begin
            presc_q <= '0;
            tick_q  <= 1'b0;
            half_q  <= 1'b0;
            count_q <= BCD_ZERO;
            state_q <= EXPIRED;
        end else begin
            presc_q <= presc_d;
            tick_q  <= tick_d;
            half_q  <= half_d;
            count_q <= count_d;
            state_q <= state_d;
        end
    end

    assign bus.bcd_time    = count_q;
    assign bus.clk_half_hz = half_q;
    assign bus.tick_1hz    = tick_q;
    assign bus.state       = state_q;

endmodule

// File: tb/tb_parking_meter_ctrl.sv
// Directed bench for parking_meter_ctrl at CLK_HZ=10 (one tick every 10 cycles).
module tb_parking_meter_ctrl;
    import parking_meter_pkg::*;

    localparam int unsigned CLK = 10;

    localparam logic [5:0] A50  = 6'b000001;
    localparam logic [5:0] A150 = 6'b000010;
    localparam logic [5:0] A200 = 6'b000100;
    localparam logic [5:0] A500 = 6'b001000;
    localparam logic [5:0] P10  = 6'b010000;
    localparam logic [5:0] P205 = 6'b100000;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    parking_meter_if bus ();

    parking_meter_ctrl #(.CLK_HZ(CLK)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic drive(input logic [5:0] m);
        bus.add_50     = m[0];
        bus.add_150    = m[1];
        bus.add_200    = m[2];
        bus.add_500    = m[3];
        bus.preset_10  = m[4];
        bus.preset_205 = m[5];
    endtask

    // Entered at a negedge; the request is applied on the next posedge, returns one negedge later.
    task automatic pulse(input logic [5:0] m);
        drive(m);
        @(negedge clk);
        drive(6'b0);
    endtask

    // Returns at the negedge inside the n-th tick cycle seen.
    task automatic wait_ticks(input int n, input string tag);
        int seen = 0;
        int cyc  = 0;
        while (seen < n && cyc < n * CLK + 20) begin
            @(negedge clk);
            cyc++;
            if (bus.tick_1hz === 1'b1) seen++;
        end
        n_checks++;
        if (seen !== n) begin
            n_fail++;
            $display("FAIL %s_tick_wait saw %0d ticks expected %0d", tag, seen, n);
        end
    endtask

    task automatic test_reset();
        logic exp_half;
        logic exp_tick;
        rst_n = 1'b0;
        drive(6'b0);
        repeat (3) @(negedge clk);
        n_checks++; if (bus.bcd_time !== 16'h0000) begin n_fail++; $display("FAIL rst_bcd got %h expected 0000", bus.bcd_time); end
        n_checks++; if (bus.state !== EXPIRED) begin n_fail++; $display("FAIL rst_state got %0d expected %0d", bus.state, EXPIRED); end
        n_checks++; if (bus.clk_half_hz !== 1'b0) begin n_fail++; $display("FAIL rst_half got %b expected 0", bus.clk_half_hz); end
        n_checks++; if (bus.tick_1hz !== 1'b0) begin n_fail++; $display("FAIL rst_tick got %b expected 0", bus.tick_1hz); end
        rst_n = 1'b1;
        for (int i = 1; i <= 25; i++) begin
            @(negedge clk);
            exp_tick = (i == 10 || i == 20);
            exp_half = (i >= 11 && i < 21);
            n_checks++; if (bus.tick_1hz !== exp_tick) begin n_fail++; $display("FAIL idle_tick cyc %0d got %b expected %b", i, bus.tick_1hz, exp_tick); end
            n_checks++; if (bus.clk_half_hz !== exp_half) begin n_fail++; $display("FAIL idle_half cyc %0d got %b expected %b", i, bus.clk_half_hz, exp_half); end
            n_checks++; if (bus.bcd_time !== 16'h0000) begin n_fail++; $display("FAIL idle_bcd cyc %0d got %h expected 0000", i, bus.bcd_time); end
        end
        n_checks++; if (bus.state !== EXPIRED) begin n_fail++; $display("FAIL idle_state got %0d expected %0d", bus.state, EXPIRED); end
    endtask

    task automatic test_low_threshold();
        pulse(P205);
        n_checks++; if (bus.bcd_time !== 16'h0205) begin n_fail++; $display("FAIL p205_bcd got %h expected 0205", bus.bcd_time); end
        n_checks++; if (bus.state !== RUNNING) begin n_fail++; $display("FAIL p205_state got %0d expected %0d", bus.state, RUNNING); end
        n_checks++; if (bus.clk_half_hz !== 1'b0) begin n_fail++; $display("FAIL p205_half got %b expected 0", bus.clk_half_hz); end
        wait_ticks(24, "low24");
        @(negedge clk);
        n_checks++; if (bus.bcd_time !== 16'h0181) begin n_fail++; $display("FAIL low_181_bcd got %h expected 0181", bus.bcd_time); end
        n_checks++; if (bus.state !== RUNNING) begin n_fail++; $display("FAIL low_181_state got %0d expected %0d", bus.state, RUNNING); end
        wait_ticks(1, "low25");
        @(negedge clk);
        n_checks++; if (bus.bcd_time !== 16'h0180) begin n_fail++; $display("FAIL low_180_bcd got %h expected 0180", bus.bcd_time); end
        n_checks++; if (bus.state !== LOW) begin n_fail++; $display("FAIL low_180_state got %0d expected %0d", bus.state, LOW); end
        wait_ticks(1, "low26");
        @(negedge clk);
        n_checks++; if (bus.bcd_time !== 16'h0179) begin n_fail++; $display("FAIL low_179_bcd got %h expected 0179", bus.bcd_time); end
        n_checks++; if (bus.state !== LOW) begin n_fail++; $display("FAIL low_179_state got %0d expected %0d", bus.state, LOW); end
    endtask

    task automatic test_borrow();
        pulse(P10);
        n_checks++; if (bus.bcd_time !== 16'h0010) begin n_fail++; $display("FAIL brw_p10_bcd got %h expected 0010", bus.bcd_time); end
        pulse(A50);
        pulse(A50);
        n_checks++; if (bus.bcd_time !== 16'h0110) begin n_fail++; $display("FAIL brw_110_bcd got %h expected 0110", bus.bcd_time); end
        wait_ticks(10, "brw10");
        @(negedge clk);
        n_checks++; if (bus.bcd_time !== 16'h0100) begin n_fail++; $display("FAIL brw_100_bcd got %h expected 0100", bus.bcd_time); end
        wait_ticks(1, "brw11");
        @(negedge clk);
        n_checks++; if (bus.bcd_time !== 16'h0099) begin n_fail++; $display("FAIL brw_099_bcd got %h expected 0099", bus.bcd_time); end
        pulse(P10);
        wait_ticks(9, "exp9");
        @(negedge clk);
        n_checks++; if (bus.bcd_time !== 16'h0001) begin n_fail++; $display("FAIL exp_001_bcd got %h expected 0001", bus.bcd_time); end
        n_checks++; if (bus.state !== LOW) begin n_fail++; $display("FAIL exp_001_state got %0d expected %0d", bus.state, LOW); end
        wait_ticks(1, "exp10");
        @(negedge clk);
        n_checks++; if (bus.bcd_time !== 16'h0000) begin n_fail++; $display("FAIL exp_000_bcd got %h expected 0000", bus.bcd_time); end
        n_checks++; if (bus.state !== EXPIRED) begin n_fail++; $display("FAIL exp_000_state got %0d expected %0d", bus.state, EXPIRED); end
        wait_ticks(5, "exp15");
        @(negedge clk);
        n_checks++; if (bus.bcd_time !== 16'h0000) begin n_fail++; $display("FAIL exp_hold_bcd got %h expected 0000", bus.bcd_time); end
        n_checks++; if (bus.state !== EXPIRED) begin n_fail++; $display("FAIL exp_hold_state got %0d expected %0d", bus.state, EXPIRED); end
    endtask

    // 0205 + 19*500 + 50 + 50 back-to-back spans two ticks: 205 + 9600 - 2 = 9803.
    task automatic test_saturation();
        pulse(P205);
        for (int i = 0; i < 19; i++) pulse(A500);
        pulse(A50);
        pulse(A50);
        n_checks++; if (bus.bcd_time !== 16'h9803) begin n_fail++; $display("FAIL b2b_bcd got %h expected 9803", bus.bcd_time); end
        wait_ticks(3, "sat3");
        @(negedge clk);
        n_checks++; if (bus.bcd_time !== 16'h9800) begin n_fail++; $display("FAIL sat_9800_bcd got %h expected 9800", bus.bcd_time); end
        pulse(A500);
        n_checks++; if (bus.bcd_time !== 16'h9999) begin n_fail++; $display("FAIL sat_9999_bcd got %h expected 9999", bus.bcd_time); end
        n_checks++; if (bus.state !== RUNNING) begin n_fail++; $display("FAIL sat_state got %0d expected %0d", bus.state, RUNNING); end
        wait_ticks(1, "sat_dec");
        @(negedge clk);
        n_checks++; if (bus.bcd_time !== 16'h9998) begin n_fail++; $display("FAIL sat_9998_bcd got %h expected 9998", bus.bcd_time); end
    endtask

    task automatic test_priority();
        pulse(P10);
        pulse(A200);
        pulse(A50);
        pulse(A50);
        wait_ticks(10, "pri10");
        @(negedge clk);
        n_checks++; if (bus.bcd_time !== 16'h0300) begin n_fail++; $display("FAIL pri_300_bcd got %h expected 0300", bus.bcd_time); end
        pulse(A50 | A500 | P10);
        n_checks++; if (bus.bcd_time !== 16'h0010) begin n_fail++; $display("FAIL pri_p10_bcd got %h expected 0010", bus.bcd_time); end
        n_checks++; if (bus.state !== LOW) begin n_fail++; $display("FAIL pri_p10_state got %0d expected %0d", bus.state, LOW); end
        pulse(A50 | A500);
        n_checks++; if (bus.bcd_time !== 16'h0510) begin n_fail++; $display("FAIL pri_a500_bcd got %h expected 0510", bus.bcd_time); end
        pulse(A50 | A150 | P205 | P10);
        n_checks++; if (bus.bcd_time !== 16'h0205) begin n_fail++; $display("FAIL pri_p205_bcd got %h expected 0205", bus.bcd_time); end
    endtask

    task automatic test_tick_add_and_reset();
        pulse(P10);
        pulse(A50);
        pulse(A50);
        wait_ticks(11, "sim11");
        n_checks++; if (bus.bcd_time !== 16'h0100) begin n_fail++; $display("FAIL sim_pre_bcd got %h expected 0100", bus.bcd_time); end
        pulse(A150);
        n_checks++; if (bus.bcd_time !== 16'h0249) begin n_fail++; $display("FAIL sim_249_bcd got %h expected 0249", bus.bcd_time); end
        n_checks++; if (bus.state !== RUNNING) begin n_fail++; $display("FAIL sim_249_state got %0d expected %0d", bus.state, RUNNING); end
        rst_n = 1'b0;
        drive(A500);
        @(negedge clk);
        n_checks++; if (bus.bcd_time !== 16'h0000) begin n_fail++; $display("FAIL rstreq_bcd got %h expected 0000", bus.bcd_time); end
        n_checks++; if (bus.state !== EXPIRED) begin n_fail++; $display("FAIL rstreq_state got %0d expected %0d", bus.state, EXPIRED); end
        n_checks++; if (bus.clk_half_hz !== 1'b0) begin n_fail++; $display("FAIL rstreq_half got %b expected 0", bus.clk_half_hz); end
        drive(6'b0);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        drive(6'b0);
        @(negedge clk);
        test_reset();
        test_low_threshold();
        test_borrow();
        test_saturation();
        test_priority();
        test_tick_add_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
